// File: rtl/aes_pkg.sv
// Shared AES constants: schedule geometry, round constants and the forward S-box.
// The key_expansion state encoding also lives here.
package aes_pkg;

   localparam int NR      = 10;
   localparam int WORD_W  = 32;
   localparam int KEY_W   = 128;
   localparam int NWORDS  = 4 * (NR + 1);
   localparam int SCHED_W = WORD_W * NWORDS;

   // Rcon[1] is the most significant byte.
   localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

   // S-box entry 0 is the most significant byte; each row holds 16 entries.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } ke_state_e;

   function automatic logic [7:0] rcon(input logic [3:0] round);
      if (round == 4'd0 || int'(round) > NR) return 8'h00;
      return RCON_TABLE[8*(NR - int'(round)) +: 8];
   endfunction

   function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
      return SBOX_TABLE[8*(255 - int'(b)) +: 8];
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);

   assign o_data = sbox_lookup(i_data);

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: one round key (4 words) per clock after start,
// complete 44-word schedule flagged by valid ten cycles after acceptance.
module key_expansion
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [KEY_W-1:0]     key,
   output logic                 busy,
   output logic                 valid,
   output logic [SCHED_W-1:0]   w
);

   ke_state_e            r_state;
   ke_state_e            w_state_nxt;
   logic [SCHED_W-1:0]   r_w;
   logic [3:0]           r_round;
   logic                 r_valid;

   logic                 w_accept;
   logic [KEY_W-1:0]     w_prev;
   logic [WORD_W-1:0]    w_rot;
   logic [WORD_W-1:0]    w_sub;
   logic [WORD_W-1:0]    w_g;
   logic [WORD_W-1:0]    w_n0, w_n1, w_n2, w_n3;
   logic [KEY_W-1:0]     w_next;

   assign w_accept = (r_state == ST_IDLE) && start;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_BUSY;
         ST_BUSY: if (int'(r_round) == NR) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Round r is derived from round r-1, already held in the schedule register.
   always_comb begin
      w_prev = '0;
      for (int r = 0; r < NR; r++) begin
         if (r_round == 4'(r + 1)) w_prev = r_w[SCHED_W-1-KEY_W*r -: KEY_W];
      end
   end

   assign w_rot = {w_prev[23:0], w_prev[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .i_data (w_rot[8*b +: 8]),
         .o_data (w_sub[8*b +: 8])
      );
   end

   assign w_g    = w_sub ^ {rcon(r_round), 24'h0};
   assign w_n0   = w_prev[127:96] ^ w_g;
   assign w_n1   = w_prev[95:64]  ^ w_n0;
   assign w_n2   = w_prev[63:32]  ^ w_n1;
   assign w_n3   = w_prev[31:0]   ^ w_n2;
   assign w_next = {w_n0, w_n1, w_n2, w_n3};

   // NOTE: the schedule is a flop bank, not RAM, so it can and must clear on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w     <= '0;
         r_round <= 4'd0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_w     <= {key, {(SCHED_W-KEY_W){1'b0}}};
         r_round <= 4'd1;
         r_valid <= 1'b0;
      end else if (r_state == ST_BUSY) begin
         for (int r = 1; r <= NR; r++) begin
            if (r_round == 4'(r)) r_w[SCHED_W-1-KEY_W*r -: KEY_W] <= w_next;
         end
         if (int'(r_round) == NR) begin
            r_round <= 4'd0;
            r_valid <= 1'b1;
         end else begin
            r_round <= r_round + 4'd1;
         end
      end
   end

   assign busy  = (r_state == ST_BUSY);
   assign valid = r_valid;
   assign w     = r_w;

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion using FIPS-197 and all-zero key vectors.
module tb_key_expansion;
   import aes_pkg::*;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [KEY_W-1:0]   key;
   logic               busy;
   logic               valid;
   logic [SCHED_W-1:0] w;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [127:0] K_FIPS   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] F_R1     = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
   localparam logic [127:0] F_R2     = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
   localparam logic [127:0] F_R10    = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] Z_R1     = 128'h62636363_62636363_62636363_62636363;
   localparam logic [127:0] Z_R2     = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
   localparam logic [127:0] Z_R10    = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

   key_expansion dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .key   (key),
      .busy  (busy),
      .valid (valid),
      .w     (w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] rk(input int r);
      return w[SCHED_W-1-128*r -: 128];
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      key   = '0;
      repeat (2) @(negedge clk);
      check("reset_busy",  128'(busy),  128'd0);
      check("reset_valid", 128'(valid), 128'd0);
      check("reset_w",     128'(|w),    128'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // FIPS key; key changes after acceptance and a mid-run start are ignored
      key = K_FIPS; start = 1'b1;
      @(negedge clk);
      start = 1'b0; key = 128'hdeadbeef_01234567_89abcdef_fedcba98;
      check("acc_busy",   128'(busy),  128'd1);
      check("acc_valid",  128'(valid), 128'd0);
      check("acc_round0", rk(0),       K_FIPS);
      check("acc_round1", rk(1),       128'd0);
      @(negedge clk);
      check("f_round1", rk(1), F_R1);
      @(negedge clk);
      check("f_round2", rk(2), F_R2);
      repeat (2) @(negedge clk);
      start = 1'b1; key = '0;
      @(negedge clk);
      start = 1'b0;
      check("c5_busy", 128'(busy), 128'd1);
      repeat (4) @(negedge clk);
      check("c9_valid", 128'(valid), 128'd0);
      check("c9_busy",  128'(busy),  128'd1);
      @(negedge clk);
      check("c10_valid",  128'(valid), 128'd1);
      check("c10_busy",   128'(busy),  128'd0);
      check("f_round10",  rk(10),      F_R10);
      check("f_round1b",  rk(1),       F_R1);
      check("f_round0",   rk(0),       K_FIPS);
      repeat (3) @(negedge clk);
      check("hold_valid",   128'(valid), 128'd1);
      check("hold_round10", rk(10),      F_R10);

      // asynchronous reset mid-expansion
      key = K_FIPS; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_w",     128'(|w),    128'd0);
      check("abort_busy",  128'(busy),  128'd0);
      check("abort_valid", 128'(valid), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy",  128'(busy),  128'd0);
      check("idle_valid", 128'(valid), 128'd0);

      // fresh FIPS run, then back-to-back restart with zero key
      key = K_FIPS; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("r3_valid",   128'(valid), 128'd1);
      check("r3_round10", rk(10),      F_R10);
      key = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_valid",  128'(valid), 128'd0);
      check("b2b_busy",   128'(busy),  128'd1);
      check("b2b_round0", rk(0),       128'd0);
      repeat (9) @(negedge clk);
      check("b2b_c9_valid", 128'(valid), 128'd0);
      @(negedge clk);
      check("z_valid",   128'(valid), 128'd1);
      check("z_busy",    128'(busy),  128'd0);
      check("z_round1",  rk(1),       Z_R1);
      check("z_round2",  rk(2),       Z_R2);
      check("z_round10", rk(10),      Z_R10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 Parameters: none; round count fixed at 10 (AES-128), constants taken from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request expansion of key; sampled on rising edge of clk.
REQ-005 key  input  128  AES-128 cipher key; key[127:96] = word 0 (FIPS-197 byte order, MSB first).
REQ-006 busy  output  1  high while expansion in progress.
REQ-007 valid  output  1  high when w holds a complete 44-word schedule for the last accepted key.
REQ-008 w  output  1408  key schedule, 44 words; word i at w[1407-32*i -: 32]; round key r at w[1407-128*r -: 128].

Function
REQ-009 start accepted only when busy=0; start while busy=1 SHALL be ignored.
REQ-010 On acceptance edge: key latched into w[1407:1280], w[1279:0] cleared, busy set, valid cleared, round counter set to 1.
REQ-011 key changes after acceptance SHALL NOT affect the schedule.
REQ-012 One round key (4 words) per cycle: round r written on the r-th edge after acceptance, r = 1..10.
REQ-013 Word 4r = word 4r-4 XOR SubWord(RotWord(word 4r-1)) XOR {Rcon[r],24'h0}; words 4r+1..4r+3 = word (j-4) XOR word (j-1), chained within the same cycle.
REQ-014 RotWord: [a0,a1,a2,a3] -> [a1,a2,a3,a0]; SubWord: AES S-box per byte.
REQ-015 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-016 On the edge writing round 10: busy cleared, valid set; latency start-to-valid = 10 cycles.
REQ-017 valid and w SHALL hold until next accepted start or reset.
REQ-018 start on same edge that valid is already high (busy=0) SHALL be accepted (back-to-back restart).
REQ-019 Partial w contents while busy=1 are not meaningful to consumers; only valid=1 qualifies w.

Reset
REQ-020 rst_n=0 SHALL immediately force w=0, busy=0, valid=0, round counter=0, regardless of clk.
REQ-021 Reset asserted mid-expansion SHALL abort it; after release the block is idle and awaits start.

Structure
REQ-022 Shared package aes_pkg: NR=10, word/key/schedule widths, Rcon table, S-box table.
REQ-023 Sub-module aes_sbox (8-bit in, 8-bit out, combinational lookup); 4 instances for SubWord.
REQ-024 Datapath: one combinational round-key generator plus the 1408-bit schedule register and a 4-bit round counter; no other state machine required beyond idle/busy.

Verification
REQ-025 FIPS-197 vector: key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start 1 cycle -> valid after 10 cycles; round1 = a0fafe17_88542cb1_23a33939_2a6c7605; round10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; round0 = key.
REQ-026 Key all zero -> round1 = 62636363_62636363_62636363_62636363; round10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
REQ-027 start pulsed and key altered at cycle 5 of an expansion -> ignored; result identical to REQ-025 at cycle 10.
REQ-028 rst_n dropped at cycle 4 of expansion -> w=0, busy=0, valid=0 without clock edge; new start afterward completes normally.
REQ-029 start asserted on the valid-rising cycle with zero key after FIPS key -> valid drops next edge, zero-key schedule (REQ-026) valid 10 cycles later.
